// File: rtl/cu_vertex_pagerank_accumulate_pkg.sv
// Compute-unit package: bus structs, accumulator states and endianness helpers.
// Shared by the PageRank pull-mode accumulate stage and its bus interface.
package cu_vertex_pagerank_accumulate_pkg;

  localparam int VERTEX_SIZE_BITS     = 32;
  localparam int EDGE_SIZE_BITS       = 32;
  localparam int DATA_SIZE_READ_BITS  = 32;
  localparam int DATA_SIZE_WRITE_BITS = 32;
  localparam int CU_ID_BITS           = 8;

  typedef enum logic [2:0] {
    ACC_RESET,
    ACC_IDLE,
    ACC_LOAD,
    ACC_ACCUM,
    ACC_WRITE
  } pagerank_accum_state;

  typedef struct packed {
    logic [VERTEX_SIZE_BITS-1:0] id;
    logic [EDGE_SIZE_BITS-1:0]   inverse_out_degree;
    logic [EDGE_SIZE_BITS-1:0]   inverse_edges_idx;
  } vertex_payload_t;

  typedef struct packed {
    logic            valid;
    vertex_payload_t payload;
  } VertexInterface;

  typedef struct packed {
    logic [CU_ID_BITS-1:0]          cu_id_x;
    logic [CU_ID_BITS-1:0]          cu_id_y;
    logic [DATA_SIZE_READ_BITS-1:0] data;
  } edge_read_payload_t;

  typedef struct packed {
    logic               valid;
    edge_read_payload_t payload;
  } EdgeDataRead;

  typedef struct packed {
    logic [CU_ID_BITS-1:0]           cu_id_x;
    logic [CU_ID_BITS-1:0]           cu_id_y;
    logic [VERTEX_SIZE_BITS-1:0]     index;
    logic [DATA_SIZE_WRITE_BITS-1:0] data;
  } edge_write_payload_t;

  typedef struct packed {
    logic                valid;
    edge_write_payload_t payload;
  } EdgeDataWrite;

  function automatic logic [DATA_SIZE_READ_BITS-1:0] swap_endianness_data_read(
    input logic [DATA_SIZE_READ_BITS-1:0] d
  );
    logic [DATA_SIZE_READ_BITS-1:0] r;
    for (int i = 0; i < DATA_SIZE_READ_BITS / 8; i++)
      r[i*8 +: 8] = d[(DATA_SIZE_READ_BITS/8 - 1 - i)*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_SIZE_WRITE_BITS-1:0] swap_endianness_data_write(
    input logic [DATA_SIZE_WRITE_BITS-1:0] d
  );
    logic [DATA_SIZE_WRITE_BITS-1:0] r;
    for (int i = 0; i < DATA_SIZE_WRITE_BITS / 8; i++)
      r[i*8 +: 8] = d[(DATA_SIZE_WRITE_BITS/8 - 1 - i)*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/cu_vertex_pagerank_accumulate_if.sv
// Handshake bundle between the fetch stage, the accumulator and write-back.
// slave is the accumulator side; master is the surrounding fabric.
interface cu_vertex_pagerank_accumulate_if;
  import cu_vertex_pagerank_accumulate_pkg::*;

  VertexInterface vertex_job_in;
  logic           vertex_job_ready_out;
  EdgeDataRead    edge_data_read_in;
  logic           edge_data_ready_out;
  EdgeDataWrite   edge_data_write_out;
  logic           edge_data_write_ready_in;

  modport slave (
    input  vertex_job_in,
    input  edge_data_read_in,
    input  edge_data_write_ready_in,
    output vertex_job_ready_out,
    output edge_data_ready_out,
    output edge_data_write_out
  );

  modport master (
    output vertex_job_in,
    output edge_data_read_in,
    output edge_data_write_ready_in,
    input  vertex_job_ready_out,
    input  edge_data_ready_out,
    input  edge_data_write_out
  );

endinterface

// File: rtl/cu_vertex_pagerank_accumulate.sv
// PageRank pull accumulate: sums in-degree neighbour contributions per vertex
// and emits one write (index = vertex id) per job. One vertex in flight.
module cu_vertex_pagerank_accumulate
  import cu_vertex_pagerank_accumulate_pkg::*;
#(
  parameter int CU_ID_X = 0,
  parameter int CU_ID_Y = 0
) (
  input  logic                        clock,
  input  logic                        rstn,
  input  logic                        enabled_in,
  cu_vertex_pagerank_accumulate_if.slave bus,
  output logic [VERTEX_SIZE_BITS-1:0] vertex_num_counter_out,
  output logic [EDGE_SIZE_BITS-1:0]   edge_num_counter_out
);

  pagerank_accum_state             state;
  logic [VERTEX_SIZE_BITS-1:0]     id_q;
  logic [EDGE_SIZE_BITS-1:0]       degree_q;
  logic [EDGE_SIZE_BITS-1:0]       remaining;
  logic [DATA_SIZE_WRITE_BITS-1:0] sum;
  logic [DATA_SIZE_WRITE_BITS-1:0] sum_next;
  EdgeDataWrite                    wr;
  logic                            job_take;
  logic                            beat_take;
  logic                            unused_ok;

  assign bus.vertex_job_ready_out = (state == ACC_IDLE) && enabled_in;
  assign bus.edge_data_ready_out  = (state == ACC_ACCUM);
  assign bus.edge_data_write_out  = wr;

  assign job_take  = bus.vertex_job_ready_out && bus.vertex_job_in.valid;
  assign beat_take = bus.edge_data_ready_out && bus.edge_data_read_in.valid;

  // Read and write widths are equal, so the cast is a plain zero-extend/truncate.
  assign sum_next = sum + DATA_SIZE_WRITE_BITS'(
    swap_endianness_data_read(bus.edge_data_read_in.payload.data));

  assign unused_ok = ^{bus.vertex_job_in.payload.inverse_edges_idx,
                       bus.edge_data_read_in.payload.cu_id_x,
                       bus.edge_data_read_in.payload.cu_id_y};

  function automatic EdgeDataWrite make_write(
    input logic [VERTEX_SIZE_BITS-1:0]     idx,
    input logic [DATA_SIZE_WRITE_BITS-1:0] s
  );
    EdgeDataWrite w;
    w.valid           = 1'b1;
    w.payload.cu_id_x = CU_ID_BITS'(CU_ID_X);
    w.payload.cu_id_y = CU_ID_BITS'(CU_ID_Y);
    w.payload.index   = idx;
    w.payload.data    = swap_endianness_data_write(s);
    return w;
  endfunction

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state                  <= ACC_RESET;
      id_q                   <= '0;
      degree_q               <= '0;
      remaining              <= '0;
      sum                    <= '0;
      wr                     <= '0;
      vertex_num_counter_out <= '0;
      edge_num_counter_out   <= '0;
    end else begin
      unique case (state)
        ACC_RESET: state <= ACC_IDLE;
        ACC_IDLE: begin
          if (job_take) begin
            id_q     <= bus.vertex_job_in.payload.id;
            degree_q <= bus.vertex_job_in.payload.inverse_out_degree;
            sum      <= '0;
            state    <= ACC_LOAD;
          end
        end
        ACC_LOAD: begin
          if (degree_q == '0) begin
            wr    <= make_write(id_q, '0);
            state <= ACC_WRITE;
          end else begin
            remaining <= degree_q;
            state     <= ACC_ACCUM;
          end
        end
        ACC_ACCUM: begin
          if (beat_take) begin
            sum                  <= sum_next;
            remaining            <= remaining - EDGE_SIZE_BITS'(1);
            edge_num_counter_out <= edge_num_counter_out + EDGE_SIZE_BITS'(1);
            if (remaining == EDGE_SIZE_BITS'(1)) begin
              wr    <= make_write(id_q, sum_next);
              state <= ACC_WRITE;
            end
          end
        end
        ACC_WRITE: begin
          if (bus.edge_data_write_ready_in) begin
            wr                     <= '0;
            vertex_num_counter_out <= vertex_num_counter_out + VERTEX_SIZE_BITS'(1);
            state                  <= ACC_IDLE;
          end
        end
        default: state <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_vertex_pagerank_accumulate.sv
// Directed bench for the PageRank accumulate stage: vector table plus
// hand sequences for stall, back-to-back, enable drop and mid-job reset.
module tb_cu_vertex_pagerank_accumulate;
  import cu_vertex_pagerank_accumulate_pkg::*;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled_in = 1'b0;
  logic [31:0] vcnt;
  logic [31:0] ecnt;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_v = 0;
  logic [31:0] exp_e = 0;

  cu_vertex_pagerank_accumulate_if bus ();

  cu_vertex_pagerank_accumulate #(.CU_ID_X(3), .CU_ID_Y(4)) dut (
    .clock                  (clock),
    .rstn                   (rstn),
    .enabled_in             (enabled_in),
    .bus                    (bus.slave),
    .vertex_num_counter_out (vcnt),
    .edge_num_counter_out   (ecnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]       id;
    int                deg;
    logic [3:0][31:0]  d;
    logic [31:0]       exp;
    int                stall;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [31:0] id, input int deg,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] e, input int stall);
    vec_t v;
    v.id = id; v.deg = deg;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.exp = e; v.stall = stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_job(input logic [31:0] id, input logic [31:0] deg);
    bit done = 0;
    bus.vertex_job_in.valid = 1'b1;
    bus.vertex_job_in.payload.id = id;
    bus.vertex_job_in.payload.inverse_out_degree = deg;
    bus.vertex_job_in.payload.inverse_edges_idx = 32'hdead;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.vertex_job_ready_out) done = 1;
      @(negedge clock);
    end
    bus.vertex_job_in.valid = 1'b0;
    if (!done) check("job_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [31:0] data);
    bit done = 0;
    bus.edge_data_read_in.valid = 1'b1;
    bus.edge_data_read_in.payload.data = data;
    bus.edge_data_read_in.payload.cu_id_x = 8'hee;
    bus.edge_data_read_in.payload.cu_id_y = 8'hff;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.edge_data_ready_out) done = 1;
      @(negedge clock);
    end
    bus.edge_data_read_in.valid = 1'b0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic wait_write(input logic [31:0] idx, input logic [31:0] data,
                            input int stall);
    for (int i = 0; i < 50 && !bus.edge_data_write_out.valid; i++)
      @(negedge clock);
    check("wr_valid", bus.edge_data_write_out.valid, 1);
    check("wr_index", bus.edge_data_write_out.payload.index, idx);
    check("wr_data", bus.edge_data_write_out.payload.data, data);
    check("wr_cu_x", bus.edge_data_write_out.payload.cu_id_x, 3);
    check("wr_cu_y", bus.edge_data_write_out.payload.cu_id_y, 4);
    check("wr_edge_rdy", bus.edge_data_ready_out, 0);
    check("wr_job_rdy", bus.vertex_job_ready_out, 0);
    for (int s = 0; s < stall; s++) begin
      bus.edge_data_write_ready_in = 1'b0;
      @(negedge clock);
      check("stall_valid", bus.edge_data_write_out.valid, 1);
      check("stall_index", bus.edge_data_write_out.payload.index, idx);
      check("stall_data", bus.edge_data_write_out.payload.data, data);
      check("stall_job_rdy", bus.vertex_job_ready_out, 0);
    end
    bus.edge_data_write_ready_in = 1'b1;
    @(negedge clock);
    bus.edge_data_write_ready_in = 1'b0;
    exp_v++;
    check("wr_drop", bus.edge_data_write_out.valid, 0);
    check("post_job_rdy", bus.vertex_job_ready_out, enabled_in);
    check("vcnt", vcnt, exp_v);
  endtask

  initial begin
    bus.vertex_job_in = '0;
    bus.edge_data_read_in = '0;
    bus.edge_data_write_ready_in = 1'b0;

    vecs[0] = mk(5, 3, 32'h01000000, 32'h02000000, 32'h03000000, 0,
                 32'h06000000, 0);
    vecs[1] = mk(9, 0, 0, 0, 0, 0, 32'h00000000, 0);
    vecs[2] = mk(3, 2, 32'hffffffff, 32'h02000000, 0, 0, 32'h01000000, 0);
    vecs[3] = mk(7, 4, 32'h10000000, 32'h20000000, 32'h30000000,
                 32'h40000000, 32'ha0000000, 0);
    vecs[4] = mk(32'h1234, 1, 32'h00000080, 0, 0, 0, 32'h00000080, 0);
    vecs[5] = mk(11, 2, 32'h00010000, 32'hff000000, 0, 0, 32'hff010000, 5);

    #2;
    check("rst_wr_valid", bus.edge_data_write_out.valid, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_ecnt", ecnt, 0);
    @(negedge clock);
    enabled_in = 1'b1;
    check("rst_job_rdy", bus.vertex_job_ready_out, 0);
    rstn = 1'b1;
    check("rel_job_rdy", bus.vertex_job_ready_out, 0);
    @(negedge clock);
    check("idle_job_rdy", bus.vertex_job_ready_out, 1);
    check("idle_edge_rdy", bus.edge_data_ready_out, 0);

    for (int k = 0; k < 6; k++) begin
      send_job(vecs[k].id, vecs[k].deg);
      if (vecs[k].deg == 0) begin
        check("d0_early", bus.edge_data_write_out.valid, 0);
        check("d0_edge_rdy", bus.edge_data_ready_out, 0);
        @(negedge clock);
      end else begin
        for (int b = 0; b < vecs[k].deg; b++) begin
          check("pre_write", bus.edge_data_write_out.valid, 0);
          send_beat(vecs[k].d[b]);
        end
      end
      check("latency", bus.edge_data_write_out.valid, 1);
      exp_e += 32'(vecs[k].deg);
      check("ecnt", ecnt, exp_e);
      wait_write(vecs[k].id, vecs[k].exp, vecs[k].stall);
    end

    // back-to-back jobs, gap in contributions, surplus beat held off
    send_job(1, 1);
    send_beat(32'h05000000);
    wait_write(1, 32'h05000000, 0);
    send_job(2, 2);
    send_beat(32'h07000000);
    @(negedge clock);
    send_beat(32'h09000000);
    exp_e += 3;
    bus.edge_data_read_in.valid = 1'b1;
    bus.edge_data_read_in.payload.data = 32'h55000000;
    @(negedge clock);
    check("extra_rdy", bus.edge_data_ready_out, 0);
    check("extra_ecnt", ecnt, exp_e);
    bus.edge_data_read_in.valid = 1'b0;
    wait_write(2, 32'h10000000, 0);

    // enable dropped mid-job: vertex still completes, then parks
    send_job(30, 2);
    enabled_in = 1'b0;
    send_beat(32'h01000000);
    send_beat(32'h01000000);
    exp_e += 2;
    wait_write(30, 32'h02000000, 0);
    bus.vertex_job_in.valid = 1'b1;
    repeat (3) @(negedge clock);
    check("park_job_rdy", bus.vertex_job_ready_out, 0);
    check("park_no_wr", bus.edge_data_write_out.valid, 0);
    bus.vertex_job_in.valid = 1'b0;
    enabled_in = 1'b1;
    @(negedge clock);

    // reset after one of four beats
    send_job(20, 4);
    send_beat(32'h01000000);
    check("pre_rst_ecnt", ecnt, exp_e + 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_vcnt", vcnt, 0);
    check("mid_rst_ecnt", ecnt, 0);
    check("mid_rst_edge_rdy", bus.edge_data_ready_out, 0);
    check("mid_rst_wr", bus.edge_data_write_out.valid, 0);
    exp_v = 0;
    exp_e = 0;
    @(negedge clock);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_no_wr", bus.edge_data_write_out.valid, 0);
    end
    send_job(21, 2);
    send_beat(32'h03000000);
    send_beat(32'h04000000);
    exp_e += 2;
    check("post_rst_ecnt", ecnt, exp_e);
    wait_write(21, 32'h07000000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_vertex_pagerank_accumulate.md
Name: cu_vertex_pagerank_accumulate

Overview:
- Downstream consumer of the PageRank CSR PULL vertex/edge fetch stage.
- Takes one vertex job (id, in-degree), then accepts exactly that many neighbour-rank contributions (EdgeDataRead) and sums them.
- Emits one EdgeDataWrite (index = vertex id, data = sum) toward the write-back engine.
- Uses the CU_PKG structs and endianness functions.

Parameters:
- CU_ID_X, 0, compute-unit X id stamped on writes
- CU_ID_Y, 0, compute-unit Y id stamped on writes

Ports:
- clock  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  block enable
- vertex_job_in  in  VertexInterface  valid + {id, inverse_out_degree (= in-edge count), inverse_edges_idx}
- vertex_job_ready_out  out  1  vertex job accepted when valid&&ready
- edge_data_read_in  in  EdgeDataRead  valid + {cu_id_x, cu_id_y, data}, little-endian data
- edge_data_ready_out  out  1  contribution accepted when valid&&ready
- edge_data_write_out  out  EdgeDataWrite  valid + {cu_id_x, cu_id_y, index, data}
- edge_data_write_ready_in  in  1  downstream accepts write when valid&&ready
- vertex_num_counter_out  out  VERTEX_SIZE_BITS  vertices completed (write accepted)
- edge_num_counter_out  out  EDGE_SIZE_BITS  contributions accepted

Behaviour:
- Reset (rstn low, asynchronous): state ACC_RESET; all outputs, sum, remaining count and counters are 0. Release is synchronous to clock.
- ACC_RESET -> ACC_IDLE unconditionally on the next edge.
- ACC_IDLE:
  - vertex_job_ready_out = enabled_in.
  - On accept, latch id and degree, clear sum, go ACC_LOAD.
  - With enabled_in low, stay in ACC_IDLE.
- ACC_LOAD (1 cycle):
  - Degree 0 -> ACC_WRITE with sum 0.
  - Otherwise remaining = degree, go ACC_ACCUM.
- ACC_ACCUM:
  - edge_data_ready_out = 1; it is 0 in every other state.
  - Per accepted beat: sum += swap_endianness_data_read(data), zero-extended or truncated to DATA_SIZE_WRITE_BITS.
  - Addition is unsigned and wraps modulo 2^DATA_SIZE_WRITE_BITS. No saturation, no error flag.
  - Per accepted beat: remaining--, edge_num_counter_out++.
  - On the beat where remaining reaches 0, go ACC_WRITE.
  - Throughput is one contribution per cycle.
  - Incoming cu_id fields are ignored.
- ACC_WRITE:
  - edge_data_write_out.valid = 1 with index = latched id, data = swap_endianness_data_write(sum), cu_id = parameters.
  - Payload is stable while valid && !ready.
  - On accept: valid drops next cycle, vertex_num_counter_out++, go ACC_IDLE.
- Latency: last contribution accepted at cycle t -> write valid at t+1. Degree-0 job accepted at t -> write valid at t+2.
- Back-to-back jobs: the next job can be accepted in the cycle after the write handshake. There is no overlap; one vertex is in flight.
- enabled_in deasserted mid-job: the current vertex completes, including its write. The block then parks in ACC_IDLE.
- Counters wrap at their full width.
- Reset mid-operation: the partial sum is discarded and no write is emitted. The upstream stage must be reset alongside.

Decomposition:
- Add the enum pagerank_accum_state {ACC_RESET, ACC_IDLE, ACC_LOAD, ACC_ACCUM, ACC_WRITE} to CU_PKG.
- Reuse the existing VertexInterface, EdgeDataRead and EdgeDataWrite structs and the swap_endianness_data_read/write functions. No new constants.
- No sub-module: a single FSM with a datapath register set.

Test Plan:
- Job id=5, degree=3; contributions 1, 2, 3 (byte-swapped on the bus), no stalls -> one write, index=5, data=swap(6), valid 1 cycle after the 3rd beat; edge_num_counter_out=3, vertex_num_counter_out=1.
- Job id=9, degree=0 -> write index=9, data=0, valid 2 cycles after the job handshake; edge_data_ready_out never high.
- Job degree=2, contributions 0xFFFFFFFF and 0x2 (32-bit data) -> data=swap(0x1), wrap verified; no extra output.
- Degree=2, edge_data_write_ready_in held low 5 cycles -> write valid and payload stable for 6 cycles; vertex_job_ready_out stays 0 until 1 cycle after the handshake.
- Jobs id=1 deg=1 and id=2 deg=2, valid back-to-back, with a gap cycle in the contributions -> two writes in order, sums correct; extra contributions are not consumed (ready low).
- rstn pulsed low mid-ACCUM (1 of 4 beats taken) -> outputs and counters 0 immediately, no write. A fresh job afterwards produces a correct result.
